// File: rtl/trap_sequencer.sv
// Sequences trap entry and MRET/SRET: flush, CSR strobes, PC redirect; owns current privilege.
// Optional TRAP_DOUBLE_FAULT_EN: exception while busy locks the sequencer until reset.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_val,
  input  logic            mret_req,
  input  logic            sret_req,
  input  logic [15:0]     medeleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [1:0]      mstatus_mpp,
  input  logic            mstatus_spp,
  output logic [1:0]      current_priv,
  output logic            flush,
  output logic            trap_m_we,
  output logic            trap_s_we,
  output logic            xret_m_we,
  output logic            xret_s_we,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
`ifdef TRAP_DOUBLE_FAULT_EN
  output logic            double_fault,
`endif
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_COMMIT, S_REDIRECT, S_LOCKED} state_t;
  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic            deleg_q, deleg_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    deleg_d   = deleg_q;
    priv_d    = priv_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    rpc_d     = rpc_q;
    flush     = 1'b0;
    trap_m_we = 1'b0;
    trap_s_we = 1'b0;
    xret_m_we = 1'b0;
    xret_s_we = 1'b0;
    redirect  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          kind_d  = K_TRAP;
          cause_d = {{(XLEN-5){1'b0}}, exc_code};
          epc_d   = exc_pc;
          tval_d  = exc_val;
          // Codes >= 16 are never delegable, whatever bit [3:0] selects.
          deleg_d = (priv_q != 2'b11) && medeleg[exc_code[3:0]] && !exc_code[4];
          state_d = S_FLUSH;
        end else if (mret_req) begin
          kind_d  = K_MRET;
          state_d = S_FLUSH;
        end else if (sret_req) begin
          kind_d  = K_SRET;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush   = 1'b1;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_REDIRECT;
        case (kind_q)
          K_TRAP: begin
            trap_s_we = deleg_q;
            trap_m_we = !deleg_q;
            priv_d    = deleg_q ? 2'b01 : 2'b11;
            rpc_d     = deleg_q ? {stvec[XLEN-1:2], 2'b00} : {mtvec[XLEN-1:2], 2'b00};
          end
          K_MRET: begin
            xret_m_we = 1'b1;
            priv_d    = (mstatus_mpp == 2'b10) ? 2'b11 : mstatus_mpp;
            rpc_d     = {mepc[XLEN-1:1], 1'b0};
          end
          default: begin
            xret_s_we = 1'b1;
            priv_d    = {1'b0, mstatus_spp};
            rpc_d     = {sepc[XLEN-1:1], 1'b0};
          end
        endcase
      end
      S_REDIRECT: begin
        redirect = 1'b1;
        state_d  = S_IDLE;
      end
      S_LOCKED: begin
        flush = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef TRAP_DOUBLE_FAULT_EN
    if (state_q != S_IDLE && exc_valid) state_d = S_LOCKED;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_TRAP;
      deleg_q <= 1'b0;
      priv_q  <= 2'b11;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      deleg_q <= deleg_d;
      priv_q  <= priv_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
    end
  end

  assign current_priv = priv_q;
  assign trap_cause   = cause_q;
  assign trap_epc     = epc_q;
  assign trap_tval    = tval_q;
  assign redirect_pc  = rpc_q;
  assign busy         = (state_q != S_IDLE);
`ifdef TRAP_DOUBLE_FAULT_EN
  assign double_fault = (state_q == S_LOCKED);
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected sequences queued at drive time, popped at commit.
module tb_trap_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            exc_valid, mret_req, sret_req, mstatus_spp;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_pc, exc_val, mtvec, stvec, mepc, sepc;
  logic [15:0]     medeleg;
  logic [1:0]      mstatus_mpp, current_priv;
  logic            flush, trap_m_we, trap_s_we, xret_m_we, xret_s_we, redirect, busy;
  logic [XLEN-1:0] trap_cause, trap_epc, trap_tval, redirect_pc;
`ifdef TRAP_DOUBLE_FAULT_EN
  logic            double_fault;
`endif

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_val(exc_val), .mret_req(mret_req), .sret_req(sret_req),
    .medeleg(medeleg), .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
    .mstatus_mpp(mstatus_mpp), .mstatus_spp(mstatus_spp), .current_priv(current_priv),
    .flush(flush), .trap_m_we(trap_m_we), .trap_s_we(trap_s_we), .xret_m_we(xret_m_we),
    .xret_s_we(xret_s_we), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef TRAP_DOUBLE_FAULT_EN
    .double_fault(double_fault),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      we;     // {trap_m, trap_s, xret_m, xret_s}
    logic            is_trap;
    logic [XLEN-1:0] cause, epc, tval, rpc;
    logic [1:0]      priv;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] we, input logic [XLEN-1:0] cause, epc, tval,
                              input logic [XLEN-1:0] rpc, input logic [1:0] priv);
    exp_t e;
    e.we = we; e.is_trap = we[3] | we[2];
    e.cause = cause; e.epc = epc; e.tval = tval; e.rpc = rpc; e.priv = priv;
    return e;
  endfunction

  task automatic clear_req();
    exc_valid = 1'b0; mret_req = 1'b0; sret_req = 1'b0;
  endtask

  function automatic logic [3:0] strobes();
    return {trap_m_we, trap_s_we, xret_m_we, xret_s_we};
  endfunction

  // Called at the negedge where the request is already driven; checks N+1..N+4.
  task automatic run_seq(input string tag, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(negedge clk);
    clear_req();
    chk({tag, ".flush"}, {flush, busy, strobes(), redirect}, {1'b1, 1'b1, 4'b0, 1'b0});
    @(negedge clk);
    got = exp_q.pop_front();
    chk({tag, ".we"}, {flush, strobes()}, {1'b0, got.we});
    if (got.is_trap) begin
      chk({tag, ".cause"}, trap_cause, got.cause);
      chk({tag, ".epc_tval"}, {trap_epc, trap_tval}, {got.epc, got.tval});
    end
    @(negedge clk);
    chk({tag, ".redirect"}, {redirect, strobes(), redirect_pc}, {1'b1, 4'b0, got.rpc});
    chk({tag, ".priv"}, current_priv, got.priv);
    @(negedge clk);
    chk({tag, ".idle"}, {busy, redirect, flush}, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset_n = 1'b0; clear_req();
    exc_code = '0; exc_pc = '0; exc_val = '0; medeleg = '0;
    mtvec = 32'h801; stvec = 32'h400; mepc = '0; sepc = '0;
    mstatus_mpp = 2'b00; mstatus_spp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.priv", current_priv, 2'b11);
    chk("reset.outs", {flush, busy, strobes(), redirect, redirect_pc, trap_cause},
        {1'b0, 1'b0, 4'b0, 1'b0, 32'h0, 32'h0});
    reset_n = 1'b1;
    @(negedge clk);

    // Trap to M from M.
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h100; exc_val = 32'h13;
    run_seq("trap_m", mk(4'b1000, 32'd2, 32'h100, 32'h13, 32'h800, 2'b11));

    // MRET to U.
    mret_req = 1'b1; mstatus_mpp = 2'b00; mepc = 32'h205;
    run_seq("mret_u", mk(4'b0010, 0, 0, 0, 32'h204, 2'b00));

    // Delegated trap from U.
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h200; exc_val = 32'h0; medeleg = 16'h0100;
    run_seq("deleg_s", mk(4'b0100, 32'd8, 32'h200, 32'h0, 32'h400, 2'b01));

    // SRET back to U.
    sret_req = 1'b1; mstatus_spp = 1'b0; sepc = 32'h333;
    run_seq("sret_u", mk(4'b0001, 0, 0, 0, 32'h332, 2'b00));

    // Same exception from U without delegation goes to M.
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h300; exc_val = 32'h7; medeleg = 16'h0000;
    run_seq("nodeleg_m", mk(4'b1000, 32'd8, 32'h300, 32'h7, 32'h800, 2'b11));

    // MRET to S.
    mret_req = 1'b1; mstatus_mpp = 2'b01; mepc = 32'h600;
    run_seq("mret_s", mk(4'b0010, 0, 0, 0, 32'h600, 2'b01));

    // Code >= 16 from S is never delegated even with all medeleg bits set.
    exc_valid = 1'b1; exc_code = 5'd24; exc_pc = 32'h700; exc_val = 32'h55; medeleg = 16'hFFFF;
    run_seq("code24_m", mk(4'b1000, 32'd24, 32'h700, 32'h55, 32'h800, 2'b11));

    // From M, delegation bits are ignored.
    exc_valid = 1'b1; exc_code = 5'd11; exc_pc = 32'h710; exc_val = 32'h1;
    run_seq("from_m", mk(4'b1000, 32'd11, 32'h710, 32'h1, 32'h800, 2'b11));

    // SRET with spp=1, then MRET with reserved mpp=10 back to M.
    sret_req = 1'b1; mstatus_spp = 1'b1; sepc = 32'h501;
    run_seq("sret_s", mk(4'b0001, 0, 0, 0, 32'h500, 2'b01));
    mret_req = 1'b1; mstatus_mpp = 2'b10; mepc = 32'h900;
    run_seq("mret_10", mk(4'b0010, 0, 0, 0, 32'h900, 2'b11));

    // Exception and MRET together: the trap wins.
    exc_valid = 1'b1; mret_req = 1'b1; mstatus_mpp = 2'b00;
    exc_code = 5'd5; exc_pc = 32'h123; exc_val = 32'h456; medeleg = 16'h0000;
    run_seq("exc_vs_mret", mk(4'b1000, 32'd5, 32'h123, 32'h456, 32'h800, 2'b11));

    // Exception arriving during COMMIT.
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'hA00; exc_val = 32'h9;
    @(negedge clk);
    clear_req();
    chk("busy_exc.flush", flush, 1'b1);
    @(negedge clk);
    chk("busy_exc.we", strobes(), 4'b1000);
    exc_valid = 1'b1; exc_code = 5'd7; exc_pc = 32'hB00;
    @(negedge clk);
    exc_valid = 1'b0;
`ifdef TRAP_DOUBLE_FAULT_EN
    chk("dfault.set", {double_fault, flush, redirect}, 3'b110);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!flush || !double_fault || strobes() != 4'b0 || redirect) seen = 1'b1;
    end
    chk("dfault.held", seen, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("dfault.reset", {double_fault, flush, busy, current_priv}, {3'b000, 2'b11});
    @(negedge clk);
`else
    chk("busy_exc.redirect", {redirect, redirect_pc}, {1'b1, 32'h800});
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (flush || busy || strobes() != 4'b0) seen = 1'b1;
    end
    chk("busy_exc.dropped", seen, 1'b0);
    chk("busy_exc.latch", {trap_cause, trap_epc}, {32'd2, 32'hA00});
`endif

    // Reset during FLUSH from U.
    mret_req = 1'b1; mstatus_mpp = 2'b00; mepc = 32'h40;
    run_seq("mret_pre_rst", mk(4'b0010, 0, 0, 0, 32'h40, 2'b00));
    exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'hC00;
    @(negedge clk);
    clear_req();
    chk("rst_mid.flush", flush, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_mid.idle", {busy, flush, current_priv}, {1'b0, 1'b0, 2'b11});
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (strobes() != 4'b0 || redirect || busy) seen = 1'b1;
    end
    chk("rst_mid.quiet", seen, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
